// File: rtl/ram_be.sv
// ram_be: single-port synchronous RAM with per-byte write enables, a
// registered read port with a one-cycle valid flag, and a clear engine that
// writes INIT_VALUE to every word after reset or on a clr request.
//
// Storage is split into DATA_WIDTH/8 independent byte lanes
// (ram_be_lane). Each lane's write enable is its own s_be bit. During a
// sweep every lane is enabled and addressed by the sweep counter.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (enters CLEAR)
//   cen      chip enable; an access happens only when 1
//   wen      1 = write, 0 = read (qualified by cen)
//   s_be     byte write enables; bit i covers s_din[8i+7:8i]
//   s_addr   word address
//   s_din    write data
//   clr      request a full clear sweep (taken only when idle)
//   s_dout   registered read data; holds between reads
//   s_valid  s_dout carries fresh read data this cycle
//   busy     clear sweep in progress; accesses are ignored

// One byte lane of the array. The read is combinational; ram_be registers it.
// Memory contents are not reset; the clear engine initialises them.
module ram_be_lane #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout
);
    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    assign dout = mem[addr];
endmodule

module ram_be #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] s_be,
    input  logic [ADDR_WIDTH-1:0]   s_addr,
    input  logic [DATA_WIDTH-1:0]   s_din,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   s_dout,
    output logic                    s_valid,
    output logic                    busy
);
    localparam int                NUM_LANES = DATA_WIDTH / 8;
    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST    = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   cnt, cnt_next;

    // clr takes priority over a same-cycle access, which is dropped.
    logic access, wr, rd, clearing;
    assign clearing = (state == CLEAR);
    assign access   = (state == IDLE) && !clr && cen;
    assign wr       = access && wen;
    assign rd       = access && !wen;
    assign busy     = clearing;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                // clr is ignored here: a sweep never restarts itself.
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic [NUM_LANES-1:0][7:0] lane_din, lane_dout;
    logic [NUM_LANES-1:0]      lane_we;
    logic [ADDR_WIDTH-1:0]     lane_addr;

    assign lane_addr = clearing ? cnt[ADDR_WIDTH-1:0] : s_addr;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_we[i]  = clearing || (wr && s_be[i]);
        assign lane_din[i] = clearing ? INIT_VALUE[8*i +: 8] : s_din[8*i +: 8];

        ram_be_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk  (clk),
            .we   (lane_we[i]),
            .addr (lane_addr),
            .din  (lane_din[i]),
            .dout (lane_dout[i])
        );
    end

    // s_dout only moves on an accepted read; s_valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_dout  <= '0;
            s_valid <= 1'b0;
        end else begin
            s_valid <= rd;
            if (rd) s_dout <= lane_dout;
        end
    end
endmodule

// File: tb/tb_ram_be.sv
// Directed bench for ram_be. Three instances share the control pins:
//   u_dut0  64 x 256, INIT_VALUE = 0
//   u_dut1  64 x 256, INIT_VALUE = deadbeef_deadbeef (same data pins as u_dut0)
//   u_dut2  32 x 16,  INIT_VALUE = 0 (own address/data/byte-enable pins)
// Wide-instance tests keep be2 = 0 and small-instance tests keep s_be = 0,
// so a shared write never alters the other geometry's contents.
module tb_ram_be;
    logic        clk = 1'b0;
    logic        reset, cen, wen, clr;
    logic [7:0]  s_be, s_addr;
    logic [63:0] s_din;
    logic [3:0]  be2, addr2;
    logic [31:0] din2;

    logic [63:0] dout0, dout1;
    logic [31:0] dout2;
    logic        valid0, valid1, valid2, busy0, busy1, busy2;

    int n_assert = 0;
    int n_fail   = 0;
    int first0, first2;
    logic saw_valid;

    always #5 clk = ~clk;

    ram_be u_dut0 (
        .clk(clk), .reset(reset), .cen(cen), .wen(wen), .s_be(s_be),
        .s_addr(s_addr), .s_din(s_din), .clr(clr),
        .s_dout(dout0), .s_valid(valid0), .busy(busy0)
    );

    ram_be #(.INIT_VALUE(64'hdeadbeefdeadbeef)) u_dut1 (
        .clk(clk), .reset(reset), .cen(cen), .wen(wen), .s_be(s_be),
        .s_addr(s_addr), .s_din(s_din), .clr(clr),
        .s_dout(dout1), .s_valid(valid1), .busy(busy1)
    );

    ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .cen(cen), .wen(wen), .s_be(be2),
        .s_addr(addr2), .s_din(din2), .clr(clr),
        .s_dout(dout2), .s_valid(valid2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access cycle; returns #1 after the sampling edge with cen dropped.
    task automatic acc(input logic w);
        @(negedge clk);
        cen = 1'b1;
        wen = w;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic wr64(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
        s_addr = a; s_din = d; s_be = be;
        acc(1'b1);
        s_be = 8'h00;
    endtask

    task automatic rd64(input string tag, input logic [7:0] a,
                        input logic [63:0] e0, input logic [63:0] e1);
        s_addr = a;
        acc(1'b0);
        chk({tag, "_valid"}, 64'(valid0), 64'd1);
        chk({tag, "_d0"}, dout0, e0);
        chk({tag, "_d1"}, dout1, e1);
    endtask

    // Counts edges (starting with the next one) until busy0 is sampled low.
    // A read held on cen during the sweep is released as soon as busy falls.
    task automatic wait_idle();
        first0 = 0; first2 = 0; saw_valid = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (valid0 || valid1) saw_valid = 1'b1;
            if (!busy2 && first2 == 0) first2 = i;
            if (!busy0) begin
                first0 = i;
                cen = 1'b0;
                break;
            end
        end
        cen = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cen = 1'b0; wen = 1'b0; clr = 1'b0;
        s_be = '0; s_addr = '0; s_din = '0; be2 = '0; addr2 = '0; din2 = '0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy0", 64'(busy0), 64'd1);
        chk("rst_dout0", dout0, 64'd0);
        chk("rst_valid0", 64'(valid0), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd1);
        chk("rst_dout2", 64'(dout2), 64'd0);
        reset = 1'b0;

        // Sweep length after reset: 256 for the wide, 16 for the small geometry
        wait_idle();
        chk("sweep_len0", 64'(first0), 64'd256);
        chk("sweep_len2", 64'(first2), 64'd16);

        // Post-reset contents
        rd64("init00", 8'h00, 64'd0, 64'hdeadbeefdeadbeef);
        rd64("init3f", 8'h3f, 64'd0, 64'hdeadbeefdeadbeef);
        rd64("initff", 8'hff, 64'd0, 64'hdeadbeefdeadbeef);
        @(posedge clk); #1;
        chk("valid_one_cycle", 64'(valid0), 64'd0);

        // Full writes, then readback (back-to-back reads)
        wr64(8'h00, 64'h0000ffff, 8'hff);
        chk("wr_valid_low", 64'(valid0), 64'd0);
        chk("wr_dout_hold", dout0, 64'd0);
        wr64(8'h3f, 64'h00ffff00, 8'hff);
        wr64(8'hff, 64'hffff0000, 8'hff);
        rd64("full00", 8'h00, 64'h0000ffff, 64'h0000ffff);
        rd64("full3f", 8'h3f, 64'h00ffff00, 64'h00ffff00);
        rd64("fullff", 8'hff, 64'hffff0000, 64'hffff0000);
        @(posedge clk); #1;
        chk("valid_drop", 64'(valid0), 64'd0);
        chk("dout_hold", dout0, 64'hffff0000);

        // Partial writes
        wr64(8'h10, 64'h1122334455667788, 8'hff);
        wr64(8'h10, 64'haaaaaaaaaaaaaaaa, 8'h0f);
        rd64("part10", 8'h10, 64'h11223344aaaaaaaa, 64'h11223344aaaaaaaa);
        wr64(8'h10, 64'hffffffffffffffff, 8'h00);
        rd64("be0_10", 8'h10, 64'h11223344aaaaaaaa, 64'h11223344aaaaaaaa);

        // clr together with a write in IDLE: write dropped, sweep starts.
        // A read stays requested through the sweep and must not be served.
        @(negedge clk);
        s_addr = 8'h20; s_din = 64'h0123456789abcdef; s_be = 8'hff;
        clr = 1'b1; cen = 1'b1; wen = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; wen = 1'b0; s_be = 8'h00;
        chk("clr_busy", 64'(busy0), 64'd1);
        chk("clr_valid", 64'(valid0), 64'd0);
        // clr during the sweep is ignored
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        for (int i = 0; i < 2; i++) @(posedge clk);
        #1;
        wait_idle();
        chk("clr_sweep_len", 64'(first0 + 3), 64'd256);
        chk("busy_read_ignored", 64'(saw_valid), 64'd0);
        rd64("clr20", 8'h20, 64'd0, 64'hdeadbeefdeadbeef);
        rd64("clr10", 8'h10, 64'd0, 64'hdeadbeefdeadbeef);

        // Reset 100 cycles into a sweep restarts it from address 0
        wr64(8'h80, 64'h5555555555555555, 8'hff);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        for (int i = 0; i < 100; i++) @(posedge clk);
        #1;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("mid_rst_busy", 64'(busy1), 64'd1);
        wait_idle();
        chk("mid_rst_len", 64'(first0), 64'd256);
        rd64("mid00", 8'h00, 64'd0, 64'hdeadbeefdeadbeef);
        rd64("mid80", 8'h80, 64'd0, 64'hdeadbeefdeadbeef);
        rd64("midff", 8'hff, 64'd0, 64'hdeadbeefdeadbeef);

        // Small geometry: 4-bit byte enables at 0x0 and 0xf
        s_be = 8'h00;
        addr2 = 4'h0; din2 = 32'h11223344; be2 = 4'hf; acc(1'b1);
        addr2 = 4'h0; din2 = 32'haabbccdd; be2 = 4'h5; acc(1'b1);
        addr2 = 4'hf; din2 = 32'hcafef00d; be2 = 4'hf; acc(1'b1);
        addr2 = 4'hf; din2 = 32'h12345678; be2 = 4'ha; acc(1'b1);
        be2 = 4'h0;
        addr2 = 4'h0; acc(1'b0);
        chk("small0_valid", 64'(valid2), 64'd1);
        chk("small0", 64'(dout2), 64'h11bb33dd);
        addr2 = 4'hf; acc(1'b0);
        chk("smallf", 64'(dout2), 64'h12fe560d);
        addr2 = 4'h7; acc(1'b0);
        chk("small7_init", 64'(dout2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_be.md
# ram_be

Parametrised single-port synchronous RAM with per-byte write enables, a registered read port with a valid flag, and a built-in clear engine that sweeps every word to a programmable init value after reset or on request. It is the next-generation storage macro for the datapath: a drop-in for the existing 256 x 64 RAM (clk/cen/wen/s_addr/s_din/s_dout). It adds configurable geometry, partial writes and guaranteed post-reset contents.

## Interface
Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
- INIT_VALUE, 0, word written to every location by the clear engine (DATA_WIDTH bits)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cen  input  1  chip enable; access only when 1
- wen  input  1  1 = write, 0 = read (qualified by cen)
- s_be  input  DATA_WIDTH/8  byte write enables; bit i covers s_din[8i+7:8i]
- s_addr  input  ADDR_WIDTH  word address
- s_din  input  DATA_WIDTH  write data
- clr  input  1  request a full clear sweep (pulse, sampled when idle)
- s_dout  output  DATA_WIDTH  registered read data
- s_valid  output  1  s_dout holds fresh read data this cycle
- busy  output  1  clear sweep in progress; accesses ignored

## Operation
- FSM states: IDLE, CLEAR. 9-bit (ADDR_WIDTH+1) sweep counter cnt.
- reset=1 at an edge: state<=CLEAR, cnt<=0, s_dout<=0, s_valid<=0. Memory array itself is not reset; CLEAR initialises it.
- CLEAR: each cycle mem[cnt]<=INIT_VALUE, cnt<=cnt+1. On the cycle writing cnt==DEPTH-1, state<=IDLE. Sweep is exactly DEPTH cycles.
- IDLE, clr=1: state<=CLEAR, cnt<=0. clr has priority over a simultaneous cen access; that access is dropped (no write, s_valid stays 0).
- clr=1 while in CLEAR: ignored (sweep continues, no restart).
- reset mid-sweep: sweep restarts from address 0.
- IDLE, cen=1, wen=1: for each i with s_be[i]=1, mem[s_addr] byte i <= s_din byte i; other bytes unchanged. s_be=0 -> no change. s_dout holds, s_valid<=0.
- IDLE, cen=1, wen=0: s_dout<=mem[s_addr], s_valid<=1. s_be ignored.
- cen=0 or state=CLEAR: no access, s_dout holds, s_valid<=0.
- busy = (state==CLEAR), combinational from state register.
- All addresses 0..DEPTH-1 are valid; no wrap or out-of-range case exists.

## Timing
- Reset values: s_dout=0, s_valid=0, busy=1 (CLEAR entered by reset).
- After the last reset=1 edge, busy stays 1 for DEPTH edges. The first access is accepted on the edge after busy falls.
- Read latency 1: address sampled at edge N; s_dout/s_valid update after edge N. s_valid is high for exactly one cycle per read. Back-to-back reads give one word per cycle.
- Write takes effect at the sampling edge. A read of the same address on the next cycle returns the new data.
- A read issued in the cycle after a write to that address returns the written bytes merged with the untouched old bytes.
- clr accepted at edge N -> busy=1 after edge N, for DEPTH cycles.

## Test plan
- Reset 1 cycle, hold cen=0 -> busy=1 for 256 cycles, then 0. Read addr 0x00, 0x3f, 0xff -> s_dout=0, s_valid=1 one cycle after each.
- Full writes of 0x0000ffff@0x00, 0x00ffff00@0x3f, 0xffff0000@0xff (s_be=0xff), then reads -> same values back, latency 1, s_valid pulses 1 cycle each.
- Write 0x1122334455667788@0x10 with s_be=0xff, then 0xAAAAAAAAAAAAAAAA with s_be=0x0f -> read 0x11223344AAAAAAAA. With s_be=0x00 -> unchanged.
- cen=1, wen=0 asserted during busy -> s_valid stays 0. clr pulsed together with a write to 0x20 in IDLE -> write dropped, 256-cycle sweep, read 0x20 = INIT_VALUE.
- INIT_VALUE=64'hdeadbeefdeadbeef. Assert reset at sweep cycle 100 -> busy stays high 256 cycles from the new reset, then all of 0x00/0x80/0xff read 0xdeadbeefdeadbeef.
- Regenerate with DATA_WIDTH=32, ADDR_WIDTH=4 -> 16-cycle sweep. 4-bit s_be partial write and readback are correct at 0x0 and 0xf.
